// File: rtl/textlcd_pkg.sv
// rtl/textlcd_pkg.sv - shared constants and helpers for the text-LCD receiver
//
// Purpose: command match masks/values, character and DDRAM constants,
//          default row base addresses and DDRAM address arithmetic.
// Ports:   none (package).
package textlcd_pkg;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] value;
  } cmd_match_t;

  // Ordered from lowest to highest priority bit; decode checks CMD_DDRAM first.
  localparam cmd_match_t CMD_CLEAR = '{mask: 8'hFF, value: 8'h01};
  localparam cmd_match_t CMD_HOME  = '{mask: 8'hFE, value: 8'h02};
  localparam cmd_match_t CMD_ENTRY = '{mask: 8'hFC, value: 8'h04};
  localparam cmd_match_t CMD_ONOFF = '{mask: 8'hF8, value: 8'h08};
  localparam cmd_match_t CMD_SHIFT = '{mask: 8'hF0, value: 8'h10};
  localparam cmd_match_t CMD_FNSET = '{mask: 8'hE0, value: 8'h20};
  localparam cmd_match_t CMD_CGRAM = '{mask: 8'hC0, value: 8'h40};
  localparam cmd_match_t CMD_DDRAM = '{mask: 8'h80, value: 8'h80};

  localparam logic [7:0] SPACE_CHAR    = 8'h20;
  localparam logic [6:0] DDRAM_SIZE    = 7'h50;
  localparam logic [6:0] DEF_ROW1_BASE = 7'h00;
  localparam logic [6:0] DEF_ROW2_BASE = 7'h28;

  function automatic logic cmd_is(input logic [7:0] d, input cmd_match_t m);
    return (d & m.mask) == m.value;
  endfunction

  // Step the address counter one place, wrapping inside 0x00..0x4F.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
    if (up) return (a == DDRAM_SIZE - 7'd1) ? 7'd0 : a + 7'd1;
    else    return (a == 7'd0) ? DDRAM_SIZE - 7'd1 : a - 7'd1;
  endfunction

  // Fold a 7-bit set-address value into 0x00..0x4F.
  function automatic logic [6:0] addr_fold(input logic [6:0] a);
    return (a >= DDRAM_SIZE) ? a - DDRAM_SIZE : a;
  endfunction

endpackage

// File: rtl/textlcd_rx_if.sv
// rtl/textlcd_rx_if.sv - HD44780-style 8-bit LCD bus interface
//
// Purpose: groups the LCD bus pins driven by the writer.
// Signals: lcd_rs (register select), lcd_rw (1 = read), lcd_en (strobe),
//          lcd_data[7:0] (bus data).
// Modports: master = bus driver, slave = bus receiver.
interface textlcd_rx_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/textlcd_bus_capture.sv
// rtl/textlcd_bus_capture.sv - LCD bus input registers and en falling-edge detect
//
// Purpose: registers the bus once into lcdclk, keeps the previous sample and
//          flags a transfer on the lcd_en high-to-low transition.
// Ports:   lcdclk, resetn (async active-low), lcd (bus slave modport);
//          xfer_valid/xfer_rs/xfer_rw/xfer_data describe the transfer
//          captured while lcd_en was high.
module textlcd_bus_capture (
  input  logic               lcdclk,
  input  logic               resetn,
  textlcd_rx_if.slave        lcd,
  output logic               xfer_valid,
  output logic               xfer_rs,
  output logic               xfer_rw,
  output logic [7:0]         xfer_data
);

  logic       s_rs, s_rw, s_en;
  logic [7:0] s_data;
  logic       s_rs_q, s_rw_q, s_en_q;
  logic [7:0] s_data_q;

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      s_rs     <= 1'b0;
      s_rw     <= 1'b0;
      s_en     <= 1'b0;
      s_data   <= 8'h00;
      s_rs_q   <= 1'b0;
      s_rw_q   <= 1'b0;
      s_en_q   <= 1'b0;
      s_data_q <= 8'h00;
    end else begin
      s_rs     <= lcd.lcd_rs;
      s_rw     <= lcd.lcd_rw;
      s_en     <= lcd.lcd_en;
      s_data   <= lcd.lcd_data;
      s_rs_q   <= s_rs;
      s_rw_q   <= s_rw;
      s_en_q   <= s_en;
      s_data_q <= s_data;
    end
  end

  // The _q copies hold the last sample taken while en was still high.
  assign xfer_valid = s_en_q & ~s_en;
  assign xfer_rs    = s_rs_q;
  assign xfer_rw    = s_rw_q;
  assign xfer_data  = s_data_q;

endmodule

// File: rtl/textlcd_rx.sv
// rtl/textlcd_rx.sv - text-LCD bus receiver with 2x16 character shadow
//
// Purpose: decodes HD44780-style commands and data writes and keeps a
//          2x16 shadow of the display, packed four characters per word.
// Ports:   lcdclk, resetn (async active-low), lcd (bus slave modport);
//          line_a..line_d row 1, line_e..line_h row 2 ([31:24] = leftmost);
//          cur_addr, disp_on, cursor_on, blink_on, two_line;
//          wr_strobe, frame_done pulses; busy; drop_cnt (busy model only).
// Config:  define TEXTLCD_RX_BUSY_MODEL_EN to model the clear/home busy
//          window and count dropped writes.
module textlcd_rx
  import textlcd_pkg::*;
#(
  parameter logic [6:0] ROW1_BASE    = DEF_ROW1_BASE,
  parameter logic [6:0] ROW2_BASE    = DEF_ROW2_BASE,
  parameter int         CLR_BUSY_CYC = 1500
) (
  input  logic        lcdclk,
  input  logic        resetn,
  textlcd_rx_if.slave lcd,
  output logic [31:0] line_a,
  output logic [31:0] line_b,
  output logic [31:0] line_c,
  output logic [31:0] line_d,
  output logic [31:0] line_e,
  output logic [31:0] line_f,
  output logic [31:0] line_g,
  output logic [31:0] line_h,
  output logic [6:0]  cur_addr,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        two_line,
  output logic        wr_strobe,
  output logic        frame_done,
`ifdef TEXTLCD_RX_BUSY_MODEL_EN
  output logic [7:0]  drop_cnt,
`endif
  output logic        busy
);

  logic       xfer_valid, xfer_rs, xfer_rw;
  logic [7:0] xfer_data;

  textlcd_bus_capture u_capture (
    .lcdclk     (lcdclk),
    .resetn     (resetn),
    .lcd        (lcd),
    .xfer_valid (xfer_valid),
    .xfer_rs    (xfer_rs),
    .xfer_rw    (xfer_rw),
    .xfer_data  (xfer_data)
  );

  logic [7:0] cells [32];
  logic       incr;
  logic       ddram_sel;
  logic       accept;

  // Offsets wrap in 7 bits, so "< 16" covers exactly base..base+15.
  logic [6:0] off1, off2;
  logic       vis1, vis2;
  logic [4:0] cell_idx;
  assign off1     = cur_addr - ROW1_BASE;
  assign off2     = cur_addr - ROW2_BASE;
  assign vis1     = off1 < 7'd16;
  assign vis2     = off2 < 7'd16;
  assign cell_idx = vis1 ? {1'b0, off1[3:0]} : {1'b1, off2[3:0]};

  logic wr_go;
  assign wr_go = xfer_valid & ~xfer_rw & accept;

`ifdef TEXTLCD_RX_BUSY_MODEL_EN
  logic [31:0] busy_cnt;
  logic        clr_home_go;
  assign busy        = busy_cnt != 32'd0;
  assign accept      = ~busy;
  assign clr_home_go = wr_go & ~xfer_rs &
                       (cmd_is(xfer_data, CMD_CLEAR) | cmd_is(xfer_data, CMD_HOME));

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      busy_cnt <= 32'd0;
      drop_cnt <= 8'h00;
    end else begin
      if (clr_home_go)
        busy_cnt <= CLR_BUSY_CYC;
      else if (busy)
        busy_cnt <= busy_cnt - 32'd1;
      if (xfer_valid && !xfer_rw && busy && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  // Keeps the busy-window parameter referenced when the model is left out.
  logic unused_busy_cfg;
  assign unused_busy_cfg = ^CLR_BUSY_CYC;
  assign busy   = 1'b0;
  assign accept = 1'b1;
`endif

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) cells[i] <= SPACE_CHAR;
      cur_addr   <= 7'd0;
      incr       <= 1'b1;
      ddram_sel  <= 1'b1;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      if (wr_go) begin
        if (xfer_rs) begin
          if (ddram_sel) begin
            if (vis1 || vis2) begin
              cells[cell_idx] <= xfer_data;
              if (cur_addr == ROW2_BASE + 7'd15) frame_done <= 1'b1;
            end
            wr_strobe <= 1'b1;
            cur_addr  <= addr_step(cur_addr, incr);
          end
        end else if (cmd_is(xfer_data, CMD_DDRAM)) begin
          cur_addr  <= addr_fold(xfer_data[6:0]);
          ddram_sel <= 1'b1;
        end else if (cmd_is(xfer_data, CMD_CGRAM)) begin
          ddram_sel <= 1'b0;
        end else if (cmd_is(xfer_data, CMD_FNSET)) begin
          two_line <= xfer_data[3];
        end else if (cmd_is(xfer_data, CMD_SHIFT)) begin
          // Display shift (S=1) is not modelled.
          if (!xfer_data[3]) cur_addr <= addr_step(cur_addr, xfer_data[2]);
        end else if (cmd_is(xfer_data, CMD_ONOFF)) begin
          disp_on   <= xfer_data[2];
          cursor_on <= xfer_data[1];
          blink_on  <= xfer_data[0];
        end else if (cmd_is(xfer_data, CMD_ENTRY)) begin
          incr <= xfer_data[1];
        end else if (cmd_is(xfer_data, CMD_HOME)) begin
          cur_addr  <= 7'd0;
          ddram_sel <= 1'b1;
        end else if (cmd_is(xfer_data, CMD_CLEAR)) begin
          for (int i = 0; i < 32; i++) cells[i] <= SPACE_CHAR;
          cur_addr  <= 7'd0;
          incr      <= 1'b1;
          ddram_sel <= 1'b1;
        end
      end
    end
  end

  assign line_a = {cells[0],  cells[1],  cells[2],  cells[3]};
  assign line_b = {cells[4],  cells[5],  cells[6],  cells[7]};
  assign line_c = {cells[8],  cells[9],  cells[10], cells[11]};
  assign line_d = {cells[12], cells[13], cells[14], cells[15]};
  assign line_e = {cells[16], cells[17], cells[18], cells[19]};
  assign line_f = {cells[20], cells[21], cells[22], cells[23]};
  assign line_g = {cells[24], cells[25], cells[26], cells[27]};
  assign line_h = {cells[28], cells[29], cells[30], cells[31]};

endmodule

// File: doc/textlcd_rx.md
Name: textlcd_rx

Overview:
- Receiving end of the HD44780-style 8-bit text-LCD bus that our LCD writer drives.
- Samples lcd_rs/lcd_rw/lcd_en/lcd_data in the lcdclk domain and decodes each transfer on the falling edge of lcd_en.
- Maintains a 2x16 character shadow of the display and exposes it as eight 32-bit words, packed the same way the writer consumes them.
- Used as a synthesizable display model for on-chip loopback, and as the scoreboard source in system benches.

Parameters:
- ROW1_BASE, 7'h00, DDRAM address of row-1 column 0.
- ROW2_BASE, 7'h28, DDRAM address of row-2 column 0.
- CLR_BUSY_CYC, 1500, busy duration in lcdclk cycles after clear/home (used only with BUSY_MODEL_EN).

Ports:
- lcdclk  in  1  bus sampling clock.
- resetn  in  1  asynchronous active-low reset.
- lcd_rs  in  1  register select (0 = command, 1 = data).
- lcd_rw  in  1  1 = read, 0 = write.
- lcd_en  in  1  transfer strobe.
- lcd_data  in  8  bus data.
- line_a..line_d  out  32 each  row 1, columns 0-15; line_a[31:24] = column 0.
- line_e..line_h  out  32 each  row 2, columns 0-15; line_e[31:24] = column 0.
- cur_addr  out  7  DDRAM address counter.
- disp_on, cursor_on, blink_on  out  1 each  display-control bits.
- two_line  out  1  function-set N bit.
- wr_strobe  out  1  one-cycle pulse per accepted data write.
- frame_done  out  1  one-cycle pulse on a write to address ROW2_BASE+15.
- busy  out  1  tied 0 unless BUSY_MODEL_EN is defined.

Behaviour:
- Inputs are registered once (s_rs, s_rw, s_en, s_data).
- A transfer is detected when s_en_q=1 and s_en=0. It decodes the s_rs/s_rw/s_data captured while s_en was high (the previous-cycle register). Decode and state update complete in that same cycle; outputs change 1 cycle after detection.
- rw=1: ignored (no state change).
- rs=0 commands, highest set bit wins:
  - 1aaaaaaa: cur_addr = a mod 0x50; ddram_sel = 1.
  - 01xxxxxx: CGRAM address set; ddram_sel = 0.
  - 001DNFxx: two_line = N; other bits ignored.
  - 0001SRxx: if S=0, cur_addr ±1 (R=1 increments) with wrap; if S=1, ignored (display shift unsupported).
  - 00001DCB: disp_on = D, cursor_on = C, blink_on = B.
  - 000001IS: incr = I; S ignored.
  - 0000001x: cur_addr = 0; ddram_sel = 1.
  - 00000001: all 32 cells = 8'h20; cur_addr = 0; incr = 1; ddram_sel = 1.
  - 00000000: no-op.
- rs=1, rw=0 data write:
  - If ddram_sel=1 and cur_addr is in ROW1_BASE..+15 or ROW2_BASE..+15, store into that cell.
  - If ddram_sel=1, cur_addr then steps ±1 per incr, regardless of visibility.
  - If ddram_sel=0, data is discarded and cur_addr is unchanged.
  - wr_strobe pulses on every rs=1 write with ddram_sel=1.
  - frame_done pulses when the stored cell is ROW2_BASE+15.
- Address wrap: 0x4F+1 → 0x00; 0x00−1 → 0x4F. Addresses 0x50-0x7F written by a set-address command are folded mod 0x50.
- Reset values:
  - All cells = 8'h20, so line_* = 32'h20202020.
  - cur_addr = 0, incr = 1, ddram_sel = 1.
  - disp_on = cursor_on = blink_on = two_line = 0.
  - wr_strobe = frame_done = busy = 0.
- Reset asserted mid-transfer: all state returns to reset values. An en falling edge in the first sampled cycle after reset is not detected, because s_en_q resets to 0.
- lcd_en held high indefinitely: no transfer decoded.

Optional Feature:
- Macro: TEXTLCD_RX_BUSY_MODEL_EN.
- Defined:
  - Clear and return-home load a down-counter with CLR_BUSY_CYC; busy = (counter != 0).
  - Any write transfer detected while busy is dropped and increments an 8-bit saturating output drop_cnt (port present only when defined).
  - A new clear/home while busy is also dropped.
- Undefined: busy = 0, no counter, no drop_cnt port, every transfer accepted.

Decomposition:
- Shared package textlcd_pkg:
  - command match masks/values (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_ONOFF, CMD_SHIFT, CMD_FNSET, CMD_CGRAM, CMD_DDRAM);
  - SPACE_CHAR = 8'h20 and DDRAM_SIZE = 7'h50;
  - default ROW bases.
- One sub-module, textlcd_bus_capture: input registers and falling-edge detect. Outputs xfer_valid, xfer_rs, xfer_rw, xfer_data.

Test Plan:
- After reset, no strobes → every line_* = 32'h20202020, cur_addr = 0, disp_on = 0.
- Commands 38, 0E, 06, 01, 80, then data "ABCD" → two_line = 1, disp_on = 1, cursor_on = 1; line_a = 32'h41424344; cur_addr = 4; four wr_strobe pulses.
- Command A8 then 16 data bytes 8'h30..8'h3F → line_e = 32'h30313233, line_h = 32'h3C3D3E3F; frame_done pulses once, on the 16th write; cur_addr = 0x38.
- Command CF (address 0x4F), data 8'h58, data 8'h59 → 0x4F is not visible, so no visible cell changes; cur_addr wraps to 0x00 then 0x01; 8'h59 lands in row 1 column 0, so line_a[31:24] = 8'h59.
- Command 04 (decrement), command 80, data 8'h5A → stored at column 0; cur_addr = 0x4F. Command 40 (CGRAM) then data 8'h41 → no cell change, no wr_strobe.
- With TEXTLCD_RX_BUSY_MODEL_EN and CLR_BUSY_CYC = 1500: command 01, then data 8'h41 after 1000 cycles → write dropped, drop_cnt = 1. A further 8'h41 after busy clears → line_a[31:24] = 8'h41.
